// File: rtl/demux_sel_sequencer.sv
// Upstream sequencer for the 1-to-8 demux: takes one sample per enabled channel
// in ascending channel order and presents it on e1/sel for HOLD_CYCLES cycles.
module demux_sel_sequencer #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] chan_mask,
  input  logic       in_valid,
  input  logic       in_data,
  output logic       in_ready,
  output logic       e1,
  output logic       sel0,
  output logic       sel1,
  output logic       sel2,
  output logic       out_strobe,
  output logic       busy,
  output logic       done
);

  // hold counter reloads to HOLD_CYCLES-1 so HOLD spans exactly HOLD_CYCLES cycles
  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic [7:0] mask_r, mask_s;
  logic [2:0] ch_r, ch_s;
  logic [7:0] hold_cnt_r, hold_cnt_s;
  logic       e1_r, e1_s;
  logic [2:0] sel_r, sel_s;
  logic       strobe_r, strobe_s;
  logic       busy_r, busy_s;
  logic       ready_r, ready_s;
  logic       done_r, done_s;
  logic [7:0] above_s;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) begin
        idx = 3'(k);
      end
    end
    return idx;
  endfunction

  // mask bits strictly above channel c; empty means c is the last channel
  function automatic logic [7:0] bits_above(input logic [7:0] m, input logic [2:0] c);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) begin
      r[k] = m[k] && (k > int'(c));
    end
    return r;
  endfunction

  // next-state and next-output decode
  always_comb begin
    state_s    = state_r;
    mask_s     = mask_r;
    ch_s       = ch_r;
    hold_cnt_s = hold_cnt_r;
    e1_s       = e1_r;
    sel_s      = sel_r;
    strobe_s   = 1'b0;
    done_s     = 1'b0;
    above_s    = bits_above(mask_r, ch_r);
    case (state_r)
      ST_IDLE: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (start) begin
          if (chan_mask != 8'd0) begin
            mask_s  = chan_mask;
            ch_s    = lowest_set(chan_mask);
            state_s = ST_WAIT;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_s = ST_IDLE;
          e1_s    = 1'b0;
        end else if (in_valid) begin
          e1_s       = in_data;
          sel_s      = ch_r;
          strobe_s   = 1'b1;
          hold_cnt_s = HOLD_RELOAD;
          state_s    = ST_HOLD;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_s = ST_IDLE;
          e1_s    = 1'b0;
        end else if (hold_cnt_r == 8'd0) begin
          e1_s = 1'b0;
          if (above_s == 8'd0) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            ch_s    = lowest_set(above_s);
            state_s = ST_WAIT;
          end
        end else begin
          hold_cnt_s = hold_cnt_r - 8'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        e1_s    = 1'b0;
      end
    endcase
    busy_s  = (state_s != ST_IDLE);
    ready_s = (state_s == ST_WAIT);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      mask_r     <= 8'd0;
      ch_r       <= 3'd0;
      hold_cnt_r <= 8'd0;
      e1_r       <= 1'b0;
      sel_r      <= 3'd0;
      strobe_r   <= 1'b0;
      busy_r     <= 1'b0;
      ready_r    <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      mask_r     <= mask_s;
      ch_r       <= ch_s;
      hold_cnt_r <= hold_cnt_s;
      e1_r       <= e1_s;
      sel_r      <= sel_s;
      strobe_r   <= strobe_s;
      busy_r     <= busy_s;
      ready_r    <= ready_s;
      done_r     <= done_s;
    end
  end

  assign in_ready   = ready_r;
  assign e1         = e1_r;
  assign sel0       = sel_r[2];
  assign sel1       = sel_r[1];
  assign sel2       = sel_r[0];
  assign out_strobe = strobe_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Bench: two instances (HOLD_CYCLES 1 and 3) share stimulus; a channel-queue
// model is compared every cycle, with literal per-frame expectations on top.
module tb_demux_sel_sequencer;
  localparam int HV0 = 1;
  localparam int HV1 = 3;

  logic clk = 1'b0;
  logic rst, start, abort, in_valid, in_data;
  logic [7:0] chan_mask;
  logic [1:0] in_ready_o, e1_o, sel0_o, sel1_o, sel2_o, strobe_o, busy_o, done_o;

  int n_vec = 0;
  int n_bad = 0;
  logic checking = 1'b0;

  demux_sel_sequencer #(.HOLD_CYCLES(HV0)) dut_h1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .chan_mask(chan_mask),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_o[0]), .e1(e1_o[0]),
    .sel0(sel0_o[0]), .sel1(sel1_o[0]), .sel2(sel2_o[0]), .out_strobe(strobe_o[0]),
    .busy(busy_o[0]), .done(done_o[0]));

  demux_sel_sequencer #(.HOLD_CYCLES(HV1)) dut_h3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .chan_mask(chan_mask),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_o[1]), .e1(e1_o[1]),
    .sel0(sel0_o[1]), .sel1(sel1_o[1]), .sel2(sel2_o[1]), .out_strobe(strobe_o[1]),
    .busy(busy_o[1]), .done(done_o[1]));

  always #5 clk = ~clk;

  // model: remaining-channel set, cycles left in the current presentation
  logic [7:0] m_rem    [2];
  logic       m_active [2];
  int         m_hold   [2];
  logic       m_e1     [2];
  logic [2:0] m_sel    [2];
  logic       m_strobe [2];
  logic       m_done   [2];

  function automatic int hold_of(input int i);
    return (i == 0) ? HV0 : HV1;
  endfunction

  function automatic logic [2:0] low_bit(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) r = 3'(k);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_strobe[i] <= 1'b0;
      m_done[i]   <= 1'b0;
      if (rst) begin
        m_rem[i] <= 8'd0; m_active[i] <= 1'b0; m_hold[i] <= 0; m_e1[i] <= 1'b0; m_sel[i] <= 3'd0;
      end else if (!m_active[i]) begin
        if (!abort && start) begin
          if (chan_mask != 8'd0) begin
            m_rem[i] <= chan_mask; m_active[i] <= 1'b1; m_hold[i] <= 0;
          end else begin
            m_done[i] <= 1'b1;
          end
        end
      end else if (abort) begin
        m_active[i] <= 1'b0; m_hold[i] <= 0; m_e1[i] <= 1'b0;
      end else if (m_hold[i] == 0) begin
        if (in_valid) begin
          m_e1[i] <= in_data; m_sel[i] <= low_bit(m_rem[i]);
          m_strobe[i] <= 1'b1; m_hold[i] <= hold_of(i);
        end
      end else if (m_hold[i] == 1) begin
        m_e1[i] <= 1'b0; m_hold[i] <= 0;
        m_rem[i] <= m_rem[i] & (m_rem[i] - 8'd1);
        if ((m_rem[i] & (m_rem[i] - 8'd1)) == 8'd0) begin
          m_active[i] <= 1'b0; m_done[i] <= 1'b1;
        end
      end else begin
        m_hold[i] <= m_hold[i] - 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] dut_out(input int i);
    return {e1_o[i], sel0_o[i], sel1_o[i], sel2_o[i], strobe_o[i], busy_o[i], in_ready_o[i], done_o[i]};
  endfunction

  function automatic logic [7:0] model_out(input int i);
    return {m_e1[i], m_sel[i], m_strobe[i], m_active[i], m_active[i] && (m_hold[i] == 0), m_done[i]};
  endfunction

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        check((i == 0) ? "cyc_h1" : "cyc_h3", 32'(dut_out(i)), 32'(model_out(i)));
      end
    end
  end

  // event log used by the literal per-frame checks
  logic [3:0] log_p [2][64];
  int n_p      [2] = '{0, 0};
  int busy_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int e1_cnt   [2] = '{0, 0};
  int rdy_cnt  [2] = '{0, 0};

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        if (strobe_o[i] === 1'b1) begin
          log_p[i][n_p[i] % 64] <= {e1_o[i], sel0_o[i], sel1_o[i], sel2_o[i]};
          n_p[i] <= n_p[i] + 1;
        end
        busy_cnt[i] <= busy_cnt[i] + ((busy_o[i] === 1'b1) ? 1 : 0);
        done_cnt[i] <= done_cnt[i] + ((done_o[i] === 1'b1) ? 1 : 0);
        e1_cnt[i]   <= e1_cnt[i] + ((e1_o[i] === 1'b1) ? 1 : 0);
        rdy_cnt[i]  <= rdy_cnt[i] + ((in_ready_o[i] === 1'b1) ? 1 : 0);
      end
    end
  end

  int b_p [2], b_busy [2], b_done [2], b_e1 [2], b_rdy [2];

  task automatic sync();
    @(negedge clk);
    #2;
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      b_p[i] = n_p[i]; b_busy[i] = busy_cnt[i]; b_done[i] = done_cnt[i];
      b_e1[i] = e1_cnt[i]; b_rdy[i] = rdy_cnt[i];
    end
  endtask

  task automatic pres(input string nm, input int i, input int k, input logic [3:0] req);
    check(nm, 32'(log_p[i][(b_p[i] + k) % 64]), 32'(req));
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((m_active[0] || m_active[1]) && k < 400) begin
      sync();
      k++;
    end
    if (m_active[0] || m_active[1]) begin
      n_vec++; n_bad++;
      $display("FAIL %s: frame still active after %0d cycles, required idle", nm, k);
    end
    sync();
    sync();
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; abort = 1'b0; chan_mask = 8'd0; in_valid = 1'b0; in_data = 1'b0;
    repeat (2) @(posedge clk);
    #1 checking = 1'b1;
    sync();
    check("reset_h1", 32'(dut_out(0)), 32'd0);
    check("reset_h3", 32'(dut_out(1)), 32'd0);
    rst = 1'b0;

    // mask 0000_0101, data 1 then 0
    sync(); snap();
    start = 1'b1; chan_mask = 8'h05; in_valid = 1'b1; in_data = 1'b1;
    sync(); start = 1'b0;
    sync(); in_data = 1'b0;
    wait_idle("t1");
    check("t1_npres_h1", 32'(n_p[0] - b_p[0]), 32'd2);
    pres("t1_p0_h1", 0, 0, 4'b1000);
    pres("t1_p1_h1", 0, 1, 4'b0010);
    check("t1_busy_h1", 32'(busy_cnt[0] - b_busy[0]), 32'd4);
    check("t1_done_h1", 32'(done_cnt[0] - b_done[0]), 32'd1);
    check("t1_rdy_h1", 32'(rdy_cnt[0] - b_rdy[0]), 32'd2);
    pres("t1_p1_h3", 1, 1, 4'b0010);
    check("t1_busy_h3", 32'(busy_cnt[1] - b_busy[1]), 32'd8);

    // single channel 7
    sync(); snap();
    start = 1'b1; chan_mask = 8'h80; in_data = 1'b1;
    sync(); start = 1'b0;
    wait_idle("t2");
    check("t2_npres_h3", 32'(n_p[1] - b_p[1]), 32'd1);
    pres("t2_p0_h3", 1, 0, 4'b1111);
    check("t2_e1cyc_h3", 32'(e1_cnt[1] - b_e1[1]), 32'd3);
    check("t2_done_h3", 32'(done_cnt[1] - b_done[1]), 32'd1);
    check("t2_busy_h3", 32'(busy_cnt[1] - b_busy[1]), 32'd4);
    check("t2_e1cyc_h1", 32'(e1_cnt[0] - b_e1[0]), 32'd1);

    // all channels, in_valid toggling
    sync(); snap();
    start = 1'b1; chan_mask = 8'hFF; in_valid = 1'b0;
    k = 0;
    do begin
      sync();
      start = 1'b0;
      in_valid = ~in_valid;
      in_data = 1'($urandom_range(1, 0));
      k++;
    end while ((m_active[0] || m_active[1]) && k < 300);
    wait_idle("t3");
    for (int i = 0; i < 2; i++) begin
      check("t3_npres", 32'(n_p[i] - b_p[i]), 32'd8);
      for (int c = 0; c < 8; c++) begin
        check("t3_sel_order", 32'(log_p[i][(b_p[i] + c) % 64][2:0]), 32'(c));
      end
    end

    // empty mask
    sync(); snap();
    start = 1'b1; chan_mask = 8'h00; in_valid = 1'b1;
    sync(); start = 1'b0;
    sync(); sync();
    check("t4_done_h1", 32'(done_cnt[0] - b_done[0]), 32'd1);
    check("t4_busy_h1", 32'(busy_cnt[0] - b_busy[0]), 32'd0);
    check("t4_rdy_h1", 32'(rdy_cnt[0] - b_rdy[0]), 32'd0);

    // abort while idle masks a same-cycle start
    sync(); snap();
    abort = 1'b1; start = 1'b1; chan_mask = 8'hFF;
    sync(); abort = 1'b0; start = 1'b0;
    sync(); sync();
    check("t5_busy_h1", 32'(busy_cnt[0] - b_busy[0]), 32'd0);
    check("t5_done_h3", 32'(done_cnt[1] - b_done[1]), 32'd0);

    // abort during the channel-3 hold of mask 0x0F (HOLD_CYCLES=3 instance)
    sync(); snap();
    start = 1'b1; chan_mask = 8'h0F; in_valid = 1'b1; in_data = 1'b1;
    sync(); start = 1'b0;
    k = 0;
    while (!(m_active[1] && m_sel[1] == 3'd3 && m_hold[1] == 2) && k < 200) begin
      sync();
      k++;
    end
    if (!(m_active[1] && m_sel[1] == 3'd3 && m_hold[1] == 2)) begin
      n_vec++; n_bad++;
      $display("FAIL t6_reach: channel-3 hold not reached after %0d cycles", k);
    end
    abort = 1'b1;
    sync(); abort = 1'b0;
    wait_idle("t6");
    check("t6_done_h3", 32'(done_cnt[1] - b_done[1]), 32'd0);
    check("t6_npres_h3", 32'(n_p[1] - b_p[1]), 32'd4);
    check("t6_done_h1", 32'(done_cnt[0] - b_done[0]), 32'd1);
    sync(); snap();
    start = 1'b1; chan_mask = 8'h02;
    sync(); start = 1'b0;
    wait_idle("t6b");
    pres("t6b_p0_h1", 0, 0, 4'b1001);
    pres("t6b_p0_h3", 1, 0, 4'b1001);
    check("t6b_done_h3", 32'(done_cnt[1] - b_done[1]), 32'd1);

    // start/mask churn mid-frame does not disturb the sequence 0,3,5
    sync(); snap();
    start = 1'b1; chan_mask = 8'h29; in_valid = 1'b1; in_data = 1'b1;
    k = 0;
    do begin
      sync();
      start = 1'($urandom_range(1, 0));
      chan_mask = 8'($urandom);
      k++;
    end while (m_active[0] && m_active[1] && k < 100);
    start = 1'b0;
    wait_idle("t7");
    for (int i = 0; i < 2; i++) begin
      check("t7_npres", 32'(n_p[i] - b_p[i]), 32'd3);
      pres("t7_p0", i, 0, 4'b1000);
      pres("t7_p1", i, 1, 4'b1011);
      pres("t7_p2", i, 2, 4'b1101);
    end

    // reset mid-frame, then a normal frame
    sync();
    start = 1'b1; chan_mask = 8'hFF; in_valid = 1'b1; in_data = 1'b1;
    sync(); start = 1'b0;
    repeat (4) sync();
    rst = 1'b1;
    sync(); rst = 1'b0;
    check("t8_rst_h1", 32'(dut_out(0)), 32'd0);
    check("t8_rst_h3", 32'(dut_out(1)), 32'd0);
    sync(); snap();
    start = 1'b1; chan_mask = 8'h40;
    sync(); start = 1'b0;
    wait_idle("t8b");
    check("t8b_npres_h1", 32'(n_p[0] - b_p[0]), 32'd1);
    pres("t8b_p0_h1", 0, 0, 4'b1110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/demux_sel_sequencer.md
Name: demux_sel_sequencer

Overview:
Upstream driver for the 1-to-8 demultiplexer. It accepts a stream of 1-bit samples over a valid/ready handshake and distributes one sample to each enabled channel of an 8-bit channel mask, in ascending channel order. For each sample it drives the demux data input `e1` and the select lines `sel0`/`sel1`/`sel2`, holding them stable for a programmable number of cycles. It signals frame completion with a one-cycle `done` pulse.

Parameters:
- HOLD_CYCLES, default 1: number of cycles `e1` and the select lines are held per sample. Legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a frame; sampled only in IDLE.
- abort  input  1  synchronous frame abort; has priority over every other input except rst.
- chan_mask  input  8  channel enable mask, bit k enables channel k; latched on an accepted start.
- in_valid  input  1  a sample is present on in_data.
- in_data  input  1  sample bit.
- in_ready  output  1  the block accepts a sample this cycle.
- e1  output  1  data to the demux.
- sel0  output  1  channel index bit 2 (MSB).
- sel1  output  1  channel index bit 1.
- sel2  output  1  channel index bit 0 (LSB).
- out_strobe  output  1  high on the first cycle of each new e1/sel presentation.
- busy  output  1  a frame is in progress (WAIT or HOLD).
- done  output  1  one-cycle pulse at frame end.

Interface: one clock; reset is synchronous and active-high (ports clk, rst).

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; e1=0, sel0/sel1/sel2=0, in_ready=0, out_strobe=0, busy=0, done=0; latched mask and hold counter cleared. rst overrides everything, including mid-frame.
- All outputs are registered. in_ready=1 exactly when state=WAIT. busy=1 in WAIT and HOLD.
- Channel encoding: channel k drives {sel0,sel1,sel2}=k[2:0], so sel0 is the MSB.
- IDLE:
  - start=1 and chan_mask!=0: latch the mask into mask_q; ch = lowest set bit; go to WAIT.
  - start=1 and chan_mask==0: done=1 for one cycle; stay in IDLE; e1/sel unchanged.
- WAIT:
  - in_valid&&in_ready at cycle N: at N+1, e1=in_data, sel=ch, out_strobe=1 (N+1 only); hold_cnt=HOLD_CYCLES-1; go to HOLD.
  - in_valid=0: remain in WAIT indefinitely with outputs unchanged.
- HOLD:
  - e1/sel stable; in_ready=0. Decrement hold_cnt each cycle.
  - When hold_cnt==0 at an edge, e1 returns to 0 and sel keeps its last value.
  - If ch is the highest set bit of mask_q: go to IDLE, done=1 for that one cycle, busy=0.
  - Otherwise: ch = next higher set bit of mask_q; go to WAIT.
- Timing: HOLD lasts exactly HOLD_CYCLES cycles. in_ready re-asserts at N+1+HOLD_CYCLES. A full frame of M enabled channels with in_valid held high takes M*(1+HOLD_CYCLES) cycles from the first WAIT.
- start while busy: ignored. chan_mask changes mid-frame: ignored because the mask is latched.
- abort=1 in WAIT or HOLD: next edge state=IDLE, e1=0, out_strobe=0, busy=0, no done pulse; sel holds its value. abort in IDLE: no effect, and same-cycle start is ignored.
- Single enabled channel: one sample, then done.
- Mask 8'hFF: channels 0..7 in order. Mask bit 7 alone: sel=111.

Test Plan:
- Reset with HOLD_CYCLES=1; start, mask=8'b0000_0101, in_valid=1, in_data=1 then 0 -> ch0 presents e1=1 with sel=000 for 1 cycle, ch2 presents e1=0 with sel=010, done pulses when leaving the ch2 HOLD, 4 busy cycles total.
- HOLD_CYCLES=3, mask=8'h80, in_data=1 -> sel=111, e1=1 for exactly 3 cycles, out_strobe on the first only, done on the 4th cycle after accept, e1=0 afterwards.
- Mask 8'hFF, in_valid toggling 1/0 each cycle -> 8 presentations, sel stepping 000..111, in_ready never high in HOLD, no sample lost or duplicated.
- start with mask=0 -> done=1 for one cycle, busy stays 0, in_ready stays 0.
- abort asserted during ch3 HOLD of mask=8'h0F -> next cycle IDLE, e1=0, no done; a new start with mask=8'h02 runs normally at sel=001.
- rst mid-frame, and start/mask changes while busy -> all outputs return to reset values; mid-frame start/mask changes do not alter the channel sequence.
